// File: rtl/bsg_ctrl_fanin.sv
// bsg_ctrl_fanin
//   Receive end of a replicated control broadcast. width_p physically
//   separate copies of one control bit are registered, then collapsed into a
//   single glitch-filtered bit. The output only moves after every copy agrees
//   on the new value for stable_cycles_p consecutive samples. Persistent lane
//   disagreement (a route or skew fault) raises a sticky mismatch flag.
//
// Ports
//   clk_i            : clock
//   reset_i          : synchronous, active-high reset
//   i                : width_p replicated copies of the control bit
//   clear_mismatch_i : clears the sticky mismatch flag at the next edge
//   o                : filtered control bit
//   changed_o        : one-cycle pulse in the cycle after o flipped
//   mismatch_o       : sticky flag for persistent lane disagreement
module bsg_ctrl_fanin #(
  parameter int   width_p         = 128,
  parameter int   stable_cycles_p = 4,
  parameter int   max_skew_p      = 8,
  parameter logic reset_val_p     = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] i,
  input  logic               clear_mismatch_i,
  output logic               o,
  output logic               changed_o,
  output logic               mismatch_o
);

  localparam int settle_w_lp = $clog2(stable_cycles_p + 1);
  localparam int skew_w_lp   = $clog2(max_skew_p + 1);

  localparam logic [settle_w_lp-1:0] settle_done_lp = settle_w_lp'(stable_cycles_p);
  localparam logic [skew_w_lp-1:0]   skew_max_lp    = skew_w_lp'(max_skew_p);

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [width_p-1:0]     i_q;
  logic [settle_w_lp-1:0] settle_q, settle_d, settle_inc_s;
  logic [skew_w_lp-1:0]   skew_q, skew_d;
  logic                   o_q, o_d;
  logic                   changed_q, changed_d;
  logic                   mismatch_q, mismatch_d;
  logic                   uni1_s, uni0_s, dis_s, new_s, mismatch_set_s;

  // Classify the captured copies; raw i is never used for decisions.
  always_comb begin
    uni1_s       = &i_q;
    uni0_s       = ~|i_q;
    dis_s        = ~(uni1_s | uni0_s);
    new_s        = (uni1_s & ~o_q) | (uni0_s & o_q);
    settle_inc_s = settle_q + settle_w_lp'(1);
  end

  // Settle FSM: count consecutive unanimous samples at the opposite value.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    o_d       = o_q;
    changed_d = 1'b0;
    case (state_q)
      STABLE: begin
        if (new_s) begin
          // A one-sample window flips immediately without visiting SETTLE.
          if (stable_cycles_p == 1) begin
            o_d       = ~o_q;
            changed_d = 1'b1;
            settle_d  = '0;
          end else begin
            state_d  = SETTLE;
            settle_d = settle_w_lp'(1);
          end
        end else begin
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (new_s && (settle_inc_s == settle_done_lp)) begin
          o_d       = ~o_q;
          changed_d = 1'b1;
          settle_d  = '0;
          state_d   = STABLE;
        end else if (new_s) begin
          settle_d = settle_inc_s;
        end else begin
          // Old value or disagreement: the candidate was a glitch.
          settle_d = '0;
          state_d  = STABLE;
        end
      end
      default: begin
        settle_d = '0;
        state_d  = STABLE;
      end
    endcase
  end

  // Skew tracking: saturating run length of disagreeing samples.
  always_comb begin
    if (dis_s) begin
      if (skew_q == skew_max_lp) begin
        skew_d = skew_q;
      end else begin
        skew_d = skew_q + skew_w_lp'(1);
      end
    end else begin
      skew_d = '0;
    end
    // Set holds for as long as the counter sits at the limit, so it beats a
    // concurrent clear.
    mismatch_set_s = dis_s & (skew_d == skew_max_lp);
    if (mismatch_set_s) begin
      mismatch_d = 1'b1;
    end else if (clear_mismatch_i) begin
      mismatch_d = 1'b0;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= STABLE;
      i_q        <= {width_p{reset_val_p}};
      settle_q   <= '0;
      skew_q     <= '0;
      o_q        <= reset_val_p;
      changed_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i;
      settle_q   <= settle_d;
      skew_q     <= skew_d;
      o_q        <= o_d;
      changed_q  <= changed_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign o          = o_q;
  assign changed_o  = changed_q;
  assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_bsg_ctrl_fanin.sv
// Self-checking bench for bsg_ctrl_fanin (width 8, 3-sample window, skew
// limit 4). A behavioural model tracks run lengths of unanimous and
// disagreeing samples and is compared with the DUT every cycle; directed
// steps add explicit expectations for the key timing points.
module tb_bsg_ctrl_fanin;

  localparam int W    = 8;
  localparam int S    = 3;
  localparam int MAXS = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         clr;
  logic         o;
  logic         changed_o;
  logic         mismatch_o;

  int checks;
  int errors;

  // behavioural model state
  logic [W-1:0] m_ir;
  logic         m_o, m_chg, m_mis;
  int           m_run, m_skew;

  bsg_ctrl_fanin #(
    .width_p(W), .stable_cycles_p(S), .max_skew_p(MAXS), .reset_val_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_i(reset), .i(din), .clear_mismatch_i(clr),
    .o(o), .changed_o(changed_o), .mismatch_o(mismatch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge();
    bit all1, all0, dis, want;
    if (reset) begin
      m_ir = '0; m_o = 1'b0; m_chg = 1'b0; m_mis = 1'b0;
      m_run = 0; m_skew = 0;
    end else begin
      all1 = (m_ir == {W{1'b1}});
      all0 = (m_ir == {W{1'b0}});
      dis  = !(all1 || all0);
      want = (all1 && !m_o) || (all0 && m_o);
      m_chg = 1'b0;
      if (want) begin
        m_run = m_run + 1;
        if (m_run == S) begin
          m_o = !m_o; m_chg = 1'b1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (dis) m_skew = (m_skew + 1 > MAXS) ? MAXS : m_skew + 1;
      else     m_skew = 0;
      if (dis && m_skew == MAXS) m_mis = 1'b1;
      else if (clr)             m_mis = 1'b0;
      m_ir = din;
    end
  endtask

  // Drive inputs, clock once, then compare all outputs against the model.
  task automatic cyc(input logic [W-1:0] v, input logic c, input logic r);
    din = v; clr = c; reset = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("o_model", o, m_o);
    chk("changed_model", changed_o, m_chg);
    chk("mismatch_model", mismatch_o, m_mis);
  endtask

  initial begin
    logic [W-1:0] rv;
    int           hold;
    checks = 0; errors = 0;
    m_ir = '0; m_o = 1'b0; m_chg = 1'b0; m_mis = 1'b0; m_run = 0; m_skew = 0;
    din = '0; clr = 1'b0; reset = 1'b1;

    // reset, then idle at zero
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    chk("reset_o", o, 1'b0);
    chk("reset_chg", changed_o, 1'b0);
    chk("reset_mis", mismatch_o, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(8'h00, 1'b0, 1'b0);
      chk("idle_o", o, 1'b0);
      chk("idle_chg", changed_o, 1'b0);
    end

    // step to all ones: o rises after edge 3, pulse in the following cycle
    for (int k = 0; k < 6; k++) begin
      cyc(8'hFF, 1'b0, 1'b0);
      chk("step_o", o, (k >= 3) ? 1'b1 : 1'b0);
      chk("step_chg", changed_o, (k == 3) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 6; k++) cyc(8'h00, 1'b0, 1'b0);
    chk("back_to_0", o, 1'b0);

    // two-sample glitches are rejected
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(8'h00, 1'b0, 1'b0);
    chk("glitch_o", o, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hF0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(8'h00, 1'b0, 1'b0);
    chk("glitch_dis_o", o, 1'b0);

    // persistent disagreement sets the sticky flag
    for (int k = 0; k < 4; k++) cyc(8'h0F, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("skew_set", mismatch_o, 1'b1);
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("skew_sticky", mismatch_o, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("skew_clear", mismatch_o, 1'b0);

    // set wins over a concurrent clear
    for (int k = 0; k < 8; k++) cyc(8'h01, 1'b1, 1'b0);
    chk("set_wins", mismatch_o, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("set_wins_last", mismatch_o, 1'b1);
    cyc(8'h00, 1'b1, 1'b0);
    chk("clear_after", mismatch_o, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);

    // reset mid-settle needs a fresh window afterwards
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b1);
    chk("rst_mid_o", o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(8'hFF, 1'b0, 1'b0);
      chk("post_rst_o", o, (k == 3) ? 1'b1 : 1'b0);
    end

    // randomized runs compared against the model
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 8'h00;
        1:       rv = 8'hFF;
        2:       rv = 8'($urandom);
        default: rv = din;
      endcase
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) begin
        cyc(rv, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
